// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared modes, FSM states and arithmetic helpers for the noise source
package noise_pkg;

    localparam logic [1:0]  MODE_WHITE  = 2'd0;
    localparam logic [1:0]  MODE_PINK   = 2'd1;
    localparam logic [1:0]  MODE_BROWN  = 2'd2;
    localparam logic [1:0]  MODE_MUTE   = 2'd3;

    localparam logic [31:0] LFSR_MASK   = 32'h80200003;
    localparam logic [31:0] SEED_STRIDE = 32'h9E3779B9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PUBLISH = 2'd2
    } state_e;

    // Returns 16 for a zero input so callers can reject it with a range test.
    function automatic logic [4:0] ctz16(input logic [15:0] x);
        logic [4:0] r;
        r = 5'd16;
        for (int i = 15; i >= 0; i--) begin
            if (x[i]) r = 5'(i);
        end
        return r;
    endfunction

    // Symmetric clip to +/-(2^(w-1)-1); the most negative code is never produced.
    function automatic logic signed [31:0] sat_w(input logic signed [31:0] x, input int w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (x > lim)  return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1);
    endfunction

    function automatic logic [31:0] chan_seed(input logic [31:0] s, input int c);
        logic [31:0] v;
        v = s ^ (32'(c) * SEED_STRIDE);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/noise_lfsr_bank.sv
// rtl/noise_lfsr_bank.sv - per-channel 32-bit Galois LFSRs with one indexed step port
module noise_lfsr_bank
    import noise_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter logic [31:0] SEED_BASE = 32'hACE11D2B,
    localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH_W-1:0] idx_i,
    input  logic            step_i,
    input  logic            load_i,
    input  logic [31:0]     seed_i,
    output logic [31:0]     lfsr_next_o
);

    logic [31:0] lfsr_q [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) lfsr_q[c] <= chan_seed(SEED_BASE, c);
        end else if (load_i) begin
            for (int c = 0; c < NUM_CH; c++) lfsr_q[c] <= chan_seed(seed_i, c);
        end else if (step_i) begin
            lfsr_q[idx_i] <= lfsr_step(lfsr_q[idx_i]);
        end
    end

    // The consumer always wants the post-step value of the selected channel.
    assign lfsr_next_o = lfsr_step(lfsr_q[idx_i]);

endmodule

// File: rtl/multi_channel_noise_source.sv
// rtl/multi_channel_noise_source.sv - time-multiplexed white/pink/brown noise over NUM_CH channels
module multi_channel_noise_source
    import noise_pkg::*;
#(
    parameter int          WIDTH     = 18,
    parameter int          FRAC      = 14,
    parameter int          NUM_CH    = 4,
    parameter int          NUM_ROWS  = 8,
    parameter int          ROW_W     = 12,
    parameter logic [31:0] SEED_BASE = 32'hACE11D2B
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic [1:0]              mode,
    input  logic [3:0]              gain_shift,
    input  logic                    reseed,
    input  logic [31:0]             seed,
    output logic [NUM_CH*WIDTH-1:0] noise_out,
    output logic                    noise_valid,
    output logic                    overrun
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RI_W  = $clog2(NUM_ROWS);
    localparam int SUM_W = ROW_W + $clog2(NUM_ROWS + 1);

    if (NUM_CH < 1 || NUM_CH > 16 || NUM_ROWS < 2 || NUM_ROWS > 16 || FRAC >= WIDTH) begin : g_bad_params
        $error("multi_channel_noise_source: parameter out of range");
    end

    state_e                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic                    pend_q, rs_pend_q, overrun_q, valid_q;
    logic [31:0]             seed_q;
    logic [1:0]              mode_q;
    logic [3:0]              gain_q;
    logic [15:0]             cnt_q;
    logic signed [ROW_W-1:0] row_q   [NUM_CH][NUM_ROWS];
    logic signed [SUM_W-1:0] sum_q   [NUM_CH];
    logic signed [WIDTH-1:0] acc_q   [NUM_CH];
    logic signed [WIDTH-1:0] stage_q [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] out_q;

    logic                    tick_go, reseed_go;
    logic [31:0]             lfsr_nx;

    noise_lfsr_bank #(
        .NUM_CH    (NUM_CH),
        .SEED_BASE (SEED_BASE)
    ) u_lfsr (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_i       (ch_q),
        .step_i      (state_q == ST_RUN),
        .load_i      (reseed_go),
        .seed_i      (reseed ? seed : seed_q),
        .lfsr_next_o (lfsr_nx)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        tick_go   = 1'b0;
        reseed_go = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clk_en || pend_q) begin
                    tick_go = 1'b1;
                    ch_d    = '0;
                    state_d = ST_RUN;
                end else if (reseed || rs_pend_q) begin
                    reseed_go = 1'b1;
                end
            end
            ST_RUN: begin
                ch_d = ch_q + CH_W'(1);
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    ch_d    = '0;
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    logic signed [ROW_W-1:0] w, w2;
    logic [4:0]              k;
    logic                    row_upd;
    logic [RI_W-1:0]         k_idx;
    logic signed [31:0]      w_x, w2_x, row_x, sum_x, acc_x;
    logic signed [31:0]      sum_new, pink_v, acc_new, sel_v, lane_v;

    // Flipping the MSB of an unsigned field is the same as subtracting 2^(ROW_W-1).
    always_comb begin
        w       = {~lfsr_nx[ROW_W-1], lfsr_nx[ROW_W-2:0]};
        w2      = {~lfsr_nx[2*ROW_W-1], lfsr_nx[2*ROW_W-2:ROW_W]};
        k       = ctz16(cnt_q);
        row_upd = (cnt_q != 16'd0) && (k < 5'(NUM_ROWS));
        k_idx   = k[RI_W-1:0];
        w_x     = 32'(w);
        w2_x    = 32'(w2);
        row_x   = 32'(row_q[ch_q][k_idx]);
        sum_x   = 32'(sum_q[ch_q]);
        acc_x   = 32'(acc_q[ch_q]);
        sum_new = row_upd ? (sum_x - row_x + w2_x) : sum_x;
        pink_v  = sum_new + w_x;
        acc_new = sat_w(acc_x - (acc_x >>> 8) + (w_x >>> 2), WIDTH);
        sel_v   = '0;
        case (mode_q)
            MODE_WHITE: sel_v = w_x;
            MODE_PINK:  sel_v = pink_v;
            MODE_BROWN: sel_v = acc_new;
            MODE_MUTE:  sel_v = '0;
        endcase
        lane_v  = sat_w(sel_v >>> gain_q, WIDTH);
    end

    logic unused_bits;
    assign unused_bits = ^{lfsr_nx, sum_new, acc_new, lane_v, k};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            pend_q    <= 1'b0;
            rs_pend_q <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            seed_q    <= '0;
            mode_q    <= MODE_WHITE;
            gain_q    <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sum_q[c]   <= '0;
                acc_q[c]   <= '0;
                stage_q[c] <= '0;
                for (int r = 0; r < NUM_ROWS; r++) row_q[c][r] <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            valid_q <= 1'b0;

            // A tick arriving while busy (including PUBLISH) is queued once, then dropped.
            if (state_q == ST_IDLE) begin
                if (tick_go) begin
                    pend_q <= pend_q & clk_en;
                    mode_q <= mode;
                    gain_q <= gain_shift;
                end
            end else if (clk_en) begin
                if (pend_q) overrun_q <= 1'b1;
                else        pend_q    <= 1'b1;
            end

            if (reseed_go) begin
                rs_pend_q <= 1'b0;
            end else if (reseed) begin
                rs_pend_q <= 1'b1;
                seed_q    <= seed;
            end

            if (reseed_go) begin
                cnt_q <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    sum_q[c] <= '0;
                    acc_q[c] <= '0;
                    for (int r = 0; r < NUM_ROWS; r++) row_q[c][r] <= '0;
                end
            end else if (state_q == ST_RUN) begin
                if (row_upd) row_q[ch_q][k_idx] <= w2;
                sum_q[ch_q]   <= sum_new[SUM_W-1:0];
                acc_q[ch_q]   <= acc_new[WIDTH-1:0];
                stage_q[ch_q] <= lane_v[WIDTH-1:0];
            end else if (state_q == ST_PUBLISH) begin
                for (int c = 0; c < NUM_CH; c++) out_q[c*WIDTH +: WIDTH] <= stage_q[c];
                valid_q <= 1'b1;
                cnt_q   <= cnt_q + 16'd1;
            end
        end
    end

    assign noise_out   = out_q;
    assign noise_valid = valid_q;
    assign overrun     = overrun_q;

endmodule
